oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 21 ++
 rtl/oam_dma_hram.sv | 21 ++
 rtl/oam_dma.sv | 129 ++++++++++++
 tb/tb_oam_dma.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared types, address map and helpers for the OAM DMA engine
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LAST    = 16'hFFFE;
    localparam int          OAM_LEN      = 160;
    localparam logic [7:0]  OAM_LAST_IDX = 8'(OAM_LEN - 1);

    // Pages E0..FF alias down onto the work-RAM echo region.
    function automatic logic [7:0] src_page(input logic [7:0] dma_reg);
        return (dma_reg < 8'hE0) ? dma_reg : dma_reg - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_hram.sv
// rtl/oam_dma_hram.sv - 127-byte high RAM, one synchronous write port, one async read
module hram_m (
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    // Contents are deliberately left unreset.
    logic [7:0] mem_q [0:126];

    always_ff @(posedge clk) begin
        if (we_i && (addr_i != 7'h7F)) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = (addr_i == 7'h7F) ? 8'hFF : mem_q[addr_i];

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine with HRAM and CPU/memory bus arbitration
// Optional: define OAM_DMA_RESTART_EN to let an FF46 write restart a running transfer.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    input  logic [7:0]  mem_d_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_write,
    output logic        busy
);

    dma_state_t state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] dma_reg_q, dma_reg_d;

    logic       is_dma_reg;
    logic       is_hram;
    logic       dma_wr;
    logic [7:0] hram_rdata;

    assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
    assign is_hram    = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST);
    assign dma_wr     = cpu_write && is_dma_reg;

    hram_m u_hram (
        .clk     (clk),
        .we_i    (cpu_write && is_hram),
        .addr_i  (cpu_addr[6:0]),
        .wdata_i (cpu_d_out),
        .rdata_o (hram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            index_q   <= 8'd0;
            dma_reg_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            dma_reg_q <= dma_reg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        dma_reg_d = dma_reg_q;
        unique case (state_q)
            IDLE: begin
                if (dma_wr) begin
                    dma_reg_d = cpu_d_out;
                    state_d   = START;
                end
            end
            START: begin
`ifdef OAM_DMA_RESTART_EN
                if (dma_wr) begin
                    dma_reg_d = cpu_d_out;
                    state_d   = START;
                    index_d   = 8'd0;
                end else
`endif
                begin
                    state_d = ACTIVE;
                    index_d = 8'd0;
                end
            end
            ACTIVE: begin
`ifdef OAM_DMA_RESTART_EN
                if (dma_wr) begin
                    dma_reg_d = cpu_d_out;
                    state_d   = START;
                    index_d   = 8'd0;
                end else
`endif
                if (index_q == OAM_LAST_IDX) begin
                    state_d = IDLE;
                    index_d = 8'd0;
                end else begin
                    index_d = index_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_write = 1'b0;
        oam_addr  = index_q;
        oam_data  = mem_d_in;
        oam_write = 1'b0;
        busy      = 1'b0;
        cpu_d_in  = mem_d_in;

        if (state_q == ACTIVE) begin
            mem_addr  = {src_page(dma_reg_q), index_q};
            oam_write = 1'b1;
            busy      = 1'b1;
        end else if (!is_hram && !is_dma_reg) begin
            mem_write = cpu_write;
        end

        // The DMA owns the external bus while active, so the CPU sees open bus.
        if (is_hram) begin
            cpu_d_in = hram_rdata;
        end else if (is_dma_reg) begin
            cpu_d_in = dma_reg_q;
        end else if (state_q == ACTIVE) begin
            cpu_d_in = 8'hFF;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized scoreboard bench for the OAM DMA engine
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_write;
    logic        busy;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_write (cpu_write),
        .cpu_d_in  (cpu_d_in),
        .mem_addr  (mem_addr),
        .mem_d_out (mem_d_out),
        .mem_write (mem_write),
        .mem_d_in  (mem_d_in),
        .oam_addr  (oam_addr),
        .oam_data  (oam_data),
        .oam_write (oam_write),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int idx;
        int data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rx_cnt   = 0;
    logic [7:0] key;

    function automatic logic [7:0] mdl(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ key;
    endfunction

    assign mem_d_in = mdl(mem_addr);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer bytes land at {source page, index}; pages E0..FF fold down by 0x20.
    task automatic push_xfer(input int page);
        int src;
        logic [15:0] a;
        src = (page >= 224) ? page - 32 : page;
        for (int i = 0; i < 160; i++) begin
            exp_t e;
            a = 16'(src * 256 + i);
            e.addr = a;
            e.idx  = i;
            e.data = mdl(a);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (oam_write) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_oam_write: got oam_addr 0x%0h expected no write at %0t", oam_addr, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                rx_cnt++;
                chk("mem_addr", mem_addr, e.addr);
                chk("oam_addr", oam_addr, e.idx);
                chk("oam_data", oam_data, e.data);
                chk("active_mem_write", mem_write, 0);
                chk("active_busy", busy, 1);
            end
        end
    end

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_write = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_cnt < n && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        if (rx_cnt < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_rx_timeout: got %0d transfers expected %0d", rx_cnt, n);
        end
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input int exp);
        cpu_addr = a;
        #1;
        chk(name, cpu_d_in, exp);
    endtask

    task automatic start_xfer(input logic [7:0] page);
        push_xfer(page);
        rx_cnt = 0;
        cpu_wr(16'hFF46, page);
        chk("start_busy", busy, 0);
        chk("start_oam_write", oam_write, 0);
        @(posedge clk); #1;
        chk("active_entry_busy", busy, 1);
    endtask

    task automatic finish_xfer(input int n, input int exp_reg);
        wait_rx(n);
        @(negedge clk); #1;
        chk("done_busy", busy, 0);
        chk("done_queue_empty", sb_q.size(), 0);
        read_chk("dma_reg_readback", 16'hFF46, exp_reg);
    endtask

    initial begin
        logic [7:0] pages[6];
        key       = 8'($urandom);
        rst       = 1'b1;
        cpu_addr  = 16'hFF46;
        cpu_d_out = 8'h00;
        cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_oam_write", oam_write, 0);
        chk("rst_dma_reg", cpu_d_in, 8'hFF);
        chk("rst_index", oam_addr, 0);
        rst = 1'b0;

        // Idle pass-through and local decode.
        @(posedge clk); #1;
        cpu_addr = 16'h1234; cpu_d_out = 8'h77; cpu_write = 1'b1;
        #1;
        chk("idle_mem_write", mem_write, 1);
        chk("idle_mem_addr", mem_addr, 16'h1234);
        chk("idle_mem_d_out", mem_d_out, 8'h77);
        cpu_addr = 16'hFF46;
        #1;
        chk("ff46_not_forwarded", mem_write, 0);
        cpu_write = 1'b0;
        read_chk("idle_read_mem", 16'h8000, mdl(16'h8000));
        cpu_wr(16'hFF80, 8'h3C);
        read_chk("hram_first", 16'hFF80, 8'h3C);
        cpu_wr(16'hFFFE, 8'hA7);
        read_chk("hram_last", 16'hFFFE, 8'hA7);

        pages[0] = 8'hC1;
        pages[1] = 8'hF0;
        pages[2] = 8'hDF;
        pages[3] = 8'hE0;
        pages[4] = 8'($urandom);
        pages[5] = 8'($urandom);
        for (int p = 0; p < 6; p++) begin
            start_xfer(pages[p]);
            finish_xfer(160, pages[p]);
        end

        // CPU accesses while the DMA owns the bus.
        start_xfer(8'hC1);
        read_chk("active_open_bus", 16'h8000, 8'hFF);
        read_chk("active_dma_reg", 16'hFF46, 8'hC1);
        @(posedge clk); #1;
        cpu_addr = 16'hFF90; cpu_d_out = 8'h5A; cpu_write = 1'b1;
        #1;
        chk("active_hram_mem_write", mem_write, 0);
        @(posedge clk); #1;
        cpu_write = 1'b0;
        read_chk("active_hram_read", 16'hFF90, 8'h5A);
        cpu_addr = 16'h0000;
        finish_xfer(160, 8'hC1);

        // FF46 write at index 50.
        start_xfer(8'hC1);
        wait_rx(50);
`ifdef OAM_DMA_RESTART_EN
        while (sb_q.size() > 1) void'(sb_q.pop_back());
        push_xfer(8'hC2);
        cpu_wr(16'hFF46, 8'hC2);
        finish_xfer(211, 8'hC2);
`else
        cpu_wr(16'hFF46, 8'hC2);
        finish_xfer(160, 8'hC1);
`endif

        // Reset at index 80 aborts the transfer.
        start_xfer(8'hC1);
        wait_rx(80);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_oam_write", oam_write, 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("abort_rx_count", rx_cnt, 80);
        read_chk("abort_dma_reg", 16'hFF46, 8'hFF);
        read_chk("hram_survives_rst", 16'hFF90, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
